tribus_transceiver: RTL and testbench

//  Half-duplex endpoint for a shared tri-state data bus: the controlled driving side plus the

---
 rtl/tribus_if.sv | 42 ++++
 rtl/tribus_transceiver.sv | 124 ++++++++++++
 tb/tb_tribus_transceiver.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tribus_if.sv
// tribus_if
//   Local-side signal bundle of the tri-state bus transceiver. It groups the
//   valid/ready transmit stream, the receive stream, the bus strobes, the grant
//   and the debug/status flags. The board-level BUS pins stay a plain inout
//   port on the transceiver because they are a resolved net, not a variable.
//
//   stb_o     transceiver drives a qualified word on BUS this cycle
//   stb_i     remote end drives a qualified word on BUS this cycle
//   gnt       arbiter grant, this end may own the bus
//   tx_data   word to transmit
//   tx_valid  tx_data valid
//   tx_ready  word accepted at the edge when tx_valid & tx_ready
//   rx_data   last received word, held until the next capture
//   rx_valid  one-cycle pulse announcing a new rx_data
//   oe        tri-state enable of this end (debug)
//   coll      sticky collision flag
//
//   Modports: slave is the transceiver, master is the local user / bench.
interface tribus_if #(
  parameter int WIDTH = 8
);
  logic             stb_o;
  logic             stb_i;
  logic             gnt;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             oe;
  logic             coll;

  modport slave (
    input  stb_i, gnt, tx_data, tx_valid,
    output stb_o, tx_ready, rx_data, rx_valid, oe, coll
  );

  modport master (
    output stb_i, gnt, tx_data, tx_valid,
    input  stb_o, tx_ready, rx_data, rx_valid, oe, coll
  );
endinterface

// File: rtl/tribus_transceiver.sv
// tribus_transceiver
//   Half-duplex endpoint of a shared tri-state data bus. It owns the output
//   enable timing (turnaround before driving, drive window, turnaround after
//   releasing) and captures words the remote end drives while this end floats.
//
//   Parameters
//     WIDTH  bus/data width in bits
//     TURN   idle turnaround cycles before driving and after releasing (>= 1)
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; releases the bus immediately
//     bus    shared bus; driven with the transmit register while oe=1
//     port   local stream, strobes, grant and status (tribus_if.slave)
module tribus_transceiver #(
  parameter int WIDTH = 8,
  parameter int TURN  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] bus,
  tribus_if.slave          port
);

  localparam int CW = $clog2(TURN + 1);
  localparam logic [CW-1:0] LAST = CW'(TURN - 1);

  typedef enum logic [1:0] {
    IDLE,
    TA_IN,
    DRIVE,
    TA_OUT
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] drv_reg;
  logic             oe_q;
  logic             stb_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_valid_q;
  logic             coll_q;
  logic             tx_ready;

  // Accepting is only possible while owning the bus; a grant drop removes
  // ready in the same cycle so no further word is taken.
  assign tx_ready = (state == DRIVE) && port.gnt;

  // The bus floats whenever oe is low, including straight out of reset.
  assign bus = oe_q ? drv_reg : {WIDTH{1'bz}};

  assign port.tx_ready = tx_ready;
  assign port.stb_o    = stb_q;
  assign port.oe       = oe_q;
  assign port.rx_data  = rx_data_q;
  assign port.rx_valid = rx_valid_q;
  assign port.coll     = coll_q;

  // NOTE: non-blocking assignments throughout so every register in this block
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      drv_reg    <= '0;
      oe_q       <= 1'b0;
      stb_q      <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      // Receive side: capture only while floating; a remote strobe while we
      // drive means both ends were on the bus, which is flagged instead.
      rx_valid_q <= 1'b0;
      if (port.stb_i) begin
        if (oe_q) begin
          coll_q <= 1'b1;
        end else begin
          rx_data_q  <= bus;
          rx_valid_q <= 1'b1;
        end
      end

      unique case (state)
        IDLE: begin
          if (port.tx_valid && port.gnt) begin
            state <= TA_IN;
            cnt   <= '0;
          end
        end
        TA_IN: begin
          if (!port.gnt) begin
            state <= IDLE;
          end else if (cnt == LAST) begin
            state <= DRIVE;
            oe_q  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (port.tx_valid && tx_ready) begin
            drv_reg <= port.tx_data;
            stb_q   <= 1'b1;
          end else begin
            // First edge without a transfer ends the drive window.
            state <= TA_OUT;
            oe_q  <= 1'b0;
            stb_q <= 1'b0;
            cnt   <= '0;
          end
        end
        TA_OUT: begin
          if (cnt == LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tribus_transceiver.sv
// tb_tribus_transceiver
//   Bench for tribus_transceiver. A TURN=1 instance carries the directed
//   scenarios and a randomized phase; a TURN=3 instance checks turnaround
//   lengths. Accepted words and remotely driven words are pushed into
//   expectation queues; a monitor pops them whenever STB_O or RX_VALID shows.
module tb_tribus_transceiver;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         rem_oe;
  logic [W-1:0] rem_data;
  wire  [W-1:0] bus;
  wire  [W-1:0] bus3;

  tribus_if #(.WIDTH(W)) ifc ();
  tribus_if #(.WIDTH(W)) ifc3 ();

  // Remote end of the shared bus.
  assign bus = rem_oe ? rem_data : {W{1'bz}};

  tribus_transceiver #(.WIDTH(W), .TURN(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .port  (ifc.slave)
  );

  tribus_transceiver #(.WIDTH(W), .TURN(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3),
    .port  (ifc3.slave)
  );

  int checks  = 0;
  int errors  = 0;
  int acc_cnt = 0;
  int stb_cnt = 0;
  logic [W-1:0] tx_exp[$];
  logic [W-1:0] rx_exp[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(string name, string what);
    checks++;
    errors++;
    $display("FAIL %s: %s at %0t", name, what, $time);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_accept(int target, string name);
    for (int i = 0; i < 40 && acc_cnt < target; i++) @(negedge clk);
    if (acc_cnt < target) fail_now(name, "word not accepted within 40 cycles");
  endtask

  // Scoreboard input: every handshake at an edge is a word that must appear
  // on the bus with STB_O, in order.
  always @(posedge clk) begin
    if (rst_n && ifc.tx_valid && ifc.tx_ready) begin
      tx_exp.push_back(ifc.tx_data);
      acc_cnt++;
    end
  end

  always @(negedge rst_n) begin
    tx_exp.delete();
    rx_exp.delete();
  end

  // Monitor: compares whatever the DUT presents against the queues.
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (rst_n) begin
      if (ifc.stb_o) begin
        stb_cnt++;
        if (tx_exp.size() == 0) begin
          fail_now("tx_unexpected", $sformatf("STB_O with BUS=0x%0h, nothing accepted", bus));
        end else begin
          e = tx_exp.pop_front();
          check("tx_word", 32'(bus), 32'(e));
          check("tx_oe", 32'(ifc.oe), 1);
        end
      end
      if (ifc.rx_valid) begin
        if (rx_exp.size() == 0) begin
          fail_now("rx_unexpected", $sformatf("RX_VALID with RX_DATA=0x%0h", ifc.rx_data));
        end else begin
          e = rx_exp.pop_front();
          check("rx_word", 32'(ifc.rx_data), 32'(e));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int s0;
    int k;
    rst_n        = 1'b0;
    rem_oe       = 1'b0;
    rem_data     = '0;
    ifc.gnt      = 1'b0;
    ifc.tx_valid = 1'b0;
    ifc.tx_data  = '0;
    ifc.stb_i    = 1'b0;
    ifc3.gnt      = 1'b0;
    ifc3.tx_valid = 1'b0;
    ifc3.tx_data  = '0;
    ifc3.stb_i    = 1'b0;
    tick(2);

    // Reset state
    check("rst_oe", 32'(ifc.oe), 0);
    check("rst_stb_o", 32'(ifc.stb_o), 0);
    check("rst_rx_valid", 32'(ifc.rx_valid), 0);
    check("rst_rx_data", 32'(ifc.rx_data), 0);
    check("rst_coll", 32'(ifc.coll), 0);
    check("rst_tx_ready", 32'(ifc.tx_ready), 0);
    rst_n = 1'b1;
    tick(1);

    // TX burst A5,3C,FF with TURN=1
    s0 = stb_cnt;
    ifc.gnt = 1'b1; ifc.tx_valid = 1'b1; ifc.tx_data = 8'hA5;
    tick(1);
    check("ta_in_oe", 32'(ifc.oe), 0);
    check("ta_in_ready", 32'(ifc.tx_ready), 0);
    tick(1);
    check("drive_first_oe", 32'(ifc.oe), 1);
    check("drive_first_stb", 32'(ifc.stb_o), 0);
    check("drive_first_ready", 32'(ifc.tx_ready), 1);
    tick(1);
    check("burst_stb1", 32'(ifc.stb_o), 1);
    ifc.tx_data = 8'h3C;
    tick(1);
    check("burst_stb2", 32'(ifc.stb_o), 1);
    ifc.tx_data = 8'hFF;
    tick(1);
    check("burst_stb3", 32'(ifc.stb_o), 1);
    ifc.tx_valid = 1'b0;
    tick(1);
    check("ta_out_oe", 32'(ifc.oe), 0);
    check("ta_out_stb", 32'(ifc.stb_o), 0);
    tick(1);
    check("idle_oe", 32'(ifc.oe), 0);
    check("burst_len", 32'(stb_cnt - s0), 3);

    // RX of 0x5A while idle
    ifc.gnt = 1'b0;
    rem_oe = 1'b1; rem_data = 8'h5A; ifc.stb_i = 1'b1;
    rx_exp.push_back(8'h5A);
    tick(1);
    rem_oe = 1'b0; ifc.stb_i = 1'b0;
    check("rx_pulse", 32'(ifc.rx_valid), 1);
    check("rx_data", 32'(ifc.rx_data), 32'h5A);
    tick(1);
    check("rx_pulse_end", 32'(ifc.rx_valid), 0);
    check("rx_hold", 32'(ifc.rx_data), 32'h5A);

    // GNT drop after the second accepted word
    a0 = acc_cnt;
    ifc.gnt = 1'b1; ifc.tx_valid = 1'b1; ifc.tx_data = 8'h11;
    wait_accept(a0 + 1, "gnt_w1");
    ifc.tx_data = 8'h22;
    wait_accept(a0 + 2, "gnt_w2");
    ifc.tx_data = 8'h33;
    ifc.gnt = 1'b0;
    #1;
    check("gnt_drop_ready", 32'(ifc.tx_ready), 0);
    check("gnt_drop_stb", 32'(ifc.stb_o), 1);
    check("gnt_drop_bus", 32'(bus), 32'h22);
    tick(1);
    check("gnt_drop_ta_out_oe", 32'(ifc.oe), 0);
    check("gnt_drop_ta_out_stb", 32'(ifc.stb_o), 0);
    tick(3);
    check("gnt_pending_ready", 32'(ifc.tx_ready), 0);
    check("gnt_pending_count", 32'(acc_cnt - a0), 2);
    ifc.gnt = 1'b1;
    wait_accept(a0 + 3, "gnt_w3");
    ifc.tx_valid = 1'b0;
    tick(4);

    // Collision: remote strobe while this end drives
    a0 = acc_cnt;
    ifc.tx_valid = 1'b1; ifc.tx_data = 8'h44;
    wait_accept(a0 + 1, "coll_w");
    ifc.tx_valid = 1'b0;
    ifc.stb_i = 1'b1;
    tick(1);
    ifc.stb_i = 1'b0;
    check("coll_set", 32'(ifc.coll), 1);
    check("coll_no_rx", 32'(ifc.rx_valid), 0);
    tick(5);
    check("coll_sticky", 32'(ifc.coll), 1);

    // Reset asserted mid-DRIVE
    a0 = acc_cnt;
    ifc.tx_valid = 1'b1; ifc.tx_data = 8'h66;
    wait_accept(a0 + 1, "rst_w");
    ifc.tx_data = 8'h67;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_oe", 32'(ifc.oe), 0);
    check("rst_mid_stb", 32'(ifc.stb_o), 0);
    check("rst_mid_coll", 32'(ifc.coll), 0);
    check("rst_mid_rx_valid", 32'(ifc.rx_valid), 0);
    check("rst_mid_ready", 32'(ifc.tx_ready), 0);
    ifc.tx_valid = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // TURN=3: TA_IN lasts 3 cycles; TA_OUT + IDLE + TA_IN lasts 7
    ifc3.gnt = 1'b1; ifc3.tx_valid = 1'b1; ifc3.tx_data = 8'h77;
    k = 0;
    while (!ifc3.oe && k < 20) begin
      tick(1);
      k++;
    end
    check("turn3_ta_in", 32'(k), 4);
    check("turn3_ready", 32'(ifc3.tx_ready), 1);
    tick(1);
    check("turn3_stb", 32'(ifc3.stb_o), 1);
    check("turn3_bus", 32'(bus3), 32'h77);
    ifc3.tx_valid = 1'b0;
    tick(1);
    check("turn3_ta_out_oe", 32'(ifc3.oe), 0);
    ifc3.tx_valid = 1'b1; ifc3.tx_data = 8'h88;
    k = 0;
    while (!ifc3.oe && k < 30) begin
      k++;
      tick(1);
    end
    check("turn3_gap", 32'(k), 7);
    tick(1);
    check("turn3_stb2", 32'(ifc3.stb_o), 1);
    check("turn3_bus2", 32'(bus3), 32'h88);
    ifc3.tx_valid = 1'b0;
    tick(5);
    check("turn3_release", 32'(ifc3.oe), 0);
    check("turn3_coll", 32'(ifc3.coll), 0);

    // Randomized traffic on the TURN=1 instance
    repeat (24) begin
      if ($urandom_range(0, 1) == 1) begin
        int n;
        n = $urandom_range(1, 4);
        for (int j = 0; j < n; j++) begin
          int target;
          int i;
          ifc.tx_data  = W'($urandom);
          ifc.tx_valid = 1'b1;
          target = acc_cnt + 1;
          for (i = 0; i < 60 && acc_cnt < target; i++) begin
            ifc.gnt = ($urandom_range(0, 3) != 0);
            @(negedge clk);
          end
          if (acc_cnt < target) fail_now("rand_accept", "word not accepted within 60 cycles");
        end
        ifc.tx_valid = 1'b0;
        ifc.gnt = 1'($urandom_range(0, 1));
        tick(4);
      end else begin
        int n;
        n = $urandom_range(1, 4);
        for (int j = 0; j < n; j++) begin
          rem_data  = W'($urandom);
          rem_oe    = 1'b1;
          ifc.stb_i = 1'b1;
          rx_exp.push_back(rem_data);
          tick(1);
          rem_oe    = 1'b0;
          ifc.stb_i = 1'b0;
          tick($urandom_range(0, 2));
        end
        tick(2);
      end
    end
    tick(3);
    check("tx_queue_empty", 32'(tx_exp.size()), 0);
    check("rx_queue_empty", 32'(rx_exp.size()), 0);
    check("tx_all_driven", 32'(stb_cnt), 32'(acc_cnt));
    check("rand_no_coll", 32'(ifc.coll), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
